// File: rtl/regfile_pkg.sv
// Shared types and sizes for the 8-entry register file read path.
package regfile_pkg;

    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 8;
    localparam int PTR_W    = 3;

    typedef enum logic {
        IDLE,
        BEAT
    } rd_state_t;

endpackage

// File: rtl/read_operation_read_mux.sv
// Combinational 8:1 word selector over the flattened register file bus.
module read_mux
    import regfile_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [NUM_REGS*DATA_W-1:0] from_reg,
    input  logic [PTR_W-1:0]           idx,
    output logic [DATA_W-1:0]          word
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_split
        assign regs[k] = from_reg[k*DATA_W +: DATA_W];
    end

    assign word = regs[idx];

endmodule

// File: rtl/read_operation.sv
// Burst read controller: wrap-around walk of the register file over valid/ready.
// Optional even parity on rdata via the READ_PARITY_EN macro.
module read_operation
    import regfile_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       re,
    input  logic [ADDR_W-1:0]          Addr,
    input  logic [PTR_W-1:0]           len,
    input  logic [NUM_REGS*DATA_W-1:0] from_reg,
    input  logic                       rready,
    output logic [DATA_W-1:0]          rdata,
    output logic                       rvalid,
    output logic                       rlast,
    output logic                       busy,
    output logic                       err
`ifdef READ_PARITY_EN
   ,output logic                       rpar
`endif
);

    rd_state_t         state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              rlast_q, rlast_d;
    logic              err_q, err_d;
    logic              load;
    logic              addr_ok;
    logic [DATA_W-1:0] mux_word;

    // Mux is indexed by the next pointer so the word lands with the beat.
    read_mux #(
        .DATA_W   (DATA_W)
    ) u_mux (
        .from_reg (from_reg),
        .idx      (ptr_d),
        .word     (mux_word)
    );

    assign addr_ok = (Addr[ADDR_W-1:PTR_W] == '0);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        rem_d    = rem_q;
        rvalid_d = rvalid_q;
        rlast_d  = rlast_q;
        err_d    = 1'b0;
        load     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (re) begin
                    if (addr_ok) begin
                        ptr_d    = Addr[PTR_W-1:0];
                        rem_d    = len;
                        load     = 1'b1;
                        rvalid_d = 1'b1;
                        rlast_d  = (len == '0);
                        state_d  = BEAT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            BEAT: begin
                if (rready) begin
                    if (rem_q != '0) begin
                        ptr_d   = ptr_q + 3'd1;
                        rem_d   = rem_q - 3'd1;
                        load    = 1'b1;
                        rlast_d = (rem_q == 3'd1);
                    end else begin
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        rdata_d = load ? mux_word : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            rem_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            rem_q    <= rem_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
            err_q    <= err_d;
        end
    end

`ifdef READ_PARITY_EN
    logic rpar_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rpar_q <= 1'b0;
        end else if (load) begin
            rpar_q <= ^mux_word;
        end
    end

    assign rpar = rpar_q;
`endif

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign rlast  = rlast_q;
    assign busy   = (state_q != IDLE);
    assign err    = err_q;

endmodule

// File: tb/tb_read_operation.sv
// Scoreboard bench for read_operation: directed bursts, stalls, errors, reset.
module tb_read_operation;

    logic        clk;
    logic        reset;
    logic        re;
    logic [7:0]  Addr;
    logic [2:0]  len;
    logic [63:0] from_reg;
    logic        rready;
    logic [7:0]  rdata;
    logic        rvalid;
    logic        rlast;
    logic        busy;
    logic        err;
`ifdef READ_PARITY_EN
    logic        rpar;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    beat_t exp_q[$];

    read_operation #(
        .DATA_W   (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .re       (re),
        .Addr     (Addr),
        .len      (len),
        .from_reg (from_reg),
        .rready   (rready),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .rlast    (rlast),
        .busy     (busy),
        .err      (err)
`ifdef READ_PARITY_EN
       ,.rpar     (rpar)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        exp_q.push_back(b);
    endtask

    task automatic set_reg(input int k, input logic [7:0] v);
        from_reg[k*8 +: 8] = v;
    endtask

    // Monitor: every accepted beat is popped and compared.
    always @(negedge clk) begin
        if (!reset && rvalid && rready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %0h expected none", rdata);
            end else begin
                beat_t b;
                b = exp_q.pop_front();
                chk("beat_data", {24'd0, rdata}, {24'd0, b.d});
                chk("beat_last", {31'd0, rlast}, {31'd0, b.l});
            end
        end
    end

    // Presents a request at the next edge; returns just after the load edge.
    task automatic issue(input logic [7:0] a, input logic [2:0] n);
        re   = 1'b1;
        Addr = a;
        len  = n;
        @(posedge clk);
        #1;
        re = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got busy expected idle");
        end
    endtask

    int cyc;

    initial begin
        reset  = 1'b1;
        re     = 1'b0;
        Addr   = 8'h00;
        len    = 3'd0;
        rready = 1'b1;
        for (int k = 0; k < 8; k++) set_reg(k, 8'h10 + 8'(k));
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", {24'd0, rdata}, 32'h0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'h0);
        chk("rst_rlast", {31'd0, rlast}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_err", {31'd0, err}, 32'h0);
`ifdef READ_PARITY_EN
        chk("rst_rpar", {31'd0, rpar}, 32'h0);
`endif
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single read
        push(8'h13, 1'b1);
        issue(8'h03, 3'd0);
        chk("single_rvalid", {31'd0, rvalid}, 32'h1);
        chk("single_rlast", {31'd0, rlast}, 32'h1);
        chk("single_busy", {31'd0, busy}, 32'h1);
        wait_idle(cyc);
        chk("single_cycles", cyc, 32'd1);
        chk("single_rvalid_off", {31'd0, rvalid}, 32'h0);

        // Wrap burst
        push(8'h16, 1'b0);
        push(8'h17, 1'b0);
        push(8'h10, 1'b0);
        push(8'h11, 1'b1);
        issue(8'h06, 3'd3);
        wait_idle(cyc);
        chk("wrap_cycles", cyc, 32'd4);

        // Backpressure on second beat; register rewrite must not leak in
        push(8'h10, 1'b0);
        push(8'h11, 1'b0);
        push(8'h12, 1'b1);
        issue(8'h00, 3'd2);
        @(posedge clk);
        #1;
        rready = 1'b0;
        set_reg(1, 8'hAA);
        for (int i = 0; i < 3; i++) begin
            chk("stall_rvalid", {31'd0, rvalid}, 32'h1);
            chk("stall_rdata", {24'd0, rdata}, 32'h11);
            chk("stall_rlast", {31'd0, rlast}, 32'h0);
            @(posedge clk);
            #1;
        end
        chk("stall_hold", {24'd0, rdata}, 32'h11);
        set_reg(1, 8'h11);
        rready = 1'b1;
        wait_idle(cyc);
        chk("stall_cycles", cyc, 32'd2);

        // Bad address, then a good request the following cycle
        issue(8'h08, 3'd0);
        chk("bad_err", {31'd0, err}, 32'h1);
        chk("bad_rvalid", {31'd0, rvalid}, 32'h0);
        chk("bad_busy", {31'd0, busy}, 32'h0);
        push(8'h11, 1'b1);
        issue(8'h01, 3'd0);
        chk("bad_err_clr", {31'd0, err}, 32'h0);
        chk("after_bad_rvalid", {31'd0, rvalid}, 32'h1);
        wait_idle(cyc);

        // Reset on third beat of an 8-word burst
        push(8'h10, 1'b0);
        push(8'h11, 1'b0);
        issue(8'h00, 3'd7);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("rst_mid_pre", {24'd0, rdata}, 32'h12);
        rready = 1'b0;
        reset  = 1'b1;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        rready = 1'b1;
        chk("rst_mid_rvalid", {31'd0, rvalid}, 32'h0);
        chk("rst_mid_busy", {31'd0, busy}, 32'h0);
        chk("rst_mid_rdata", {24'd0, rdata}, 32'h0);
        chk("rst_mid_q", exp_q.size(), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("rst_mid_quiet", {31'd0, rvalid}, 32'h0);

        // Full wrapped burst with an ignored mid-burst request
        push(8'h14, 1'b0);
        push(8'h15, 1'b0);
        push(8'h16, 1'b0);
        push(8'h17, 1'b0);
        push(8'h10, 1'b0);
        push(8'h11, 1'b0);
        push(8'h12, 1'b0);
        push(8'h13, 1'b1);
        issue(8'h04, 3'd7);
        @(posedge clk);
        #1;
        re   = 1'b1;
        Addr = 8'h02;
        len  = 3'd0;
        @(posedge clk);
        #1;
        re = 1'b0;
        wait_idle(cyc);
        chk("full_cycles", cyc, 32'd6);
        repeat (3) @(posedge clk);
        #1;
        chk("full_quiet", {31'd0, rvalid}, 32'h0);

`ifdef READ_PARITY_EN
        set_reg(2, 8'h07);
        set_reg(3, 8'h03);
        push(8'h07, 1'b0);
        push(8'h03, 1'b1);
        issue(8'h02, 3'd1);
        chk("par_data2", {24'd0, rdata}, 32'h07);
        chk("par_rpar2", {31'd0, rpar}, 32'h1);
        @(posedge clk);
        #1;
        chk("par_data3", {24'd0, rdata}, 32'h03);
        chk("par_rpar3", {31'd0, rpar}, 32'h0);
        wait_idle(cyc);
        set_reg(2, 8'h12);
        set_reg(3, 8'h13);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
